// File: rtl/program_counter_pkg.sv
// Shared core definitions for the fetch path: address width, instruction size
// and reset vector defaults, plus the address type used by fetch, branch and imem.
package program_counter_pkg;

    localparam int          DEFAULT_PC_WIDTH     = 32;
    localparam int          DEFAULT_INSTR_BYTES  = 4;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

    typedef logic [DEFAULT_PC_WIDTH-1:0] addr_t;

endpackage : program_counter_pkg

// File: rtl/program_counter_pc_next_sel.sv
// Combinational next-PC selection: an aligned branch target wins over the
// sequential address. Reset priority is applied at the register.
module pc_next_sel
    import program_counter_pkg::*;
#(
    parameter int PC_WIDTH    = DEFAULT_PC_WIDTH,
    parameter int INSTR_BYTES = DEFAULT_INSTR_BYTES
) (
    input  logic                branch,
    input  logic [PC_WIDTH-1:0] branch_target,
    input  logic [PC_WIDTH-1:0] pc,
    output logic [PC_WIDTH-1:0] pc_next
);

    localparam logic [PC_WIDTH-1:0] STEP       = PC_WIDTH'(INSTR_BYTES);
    // Clearing the low log2(INSTR_BYTES) bits; an all-ones mask when INSTR_BYTES is 1.
    localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~(STEP - PC_WIDTH'(1));

    function automatic logic [PC_WIDTH-1:0] align_down(input logic [PC_WIDTH-1:0] addr);
        return addr & ALIGN_MASK;
    endfunction

    logic [PC_WIDTH-1:0] seq_addr;

    always_comb begin
        seq_addr = pc + STEP;
        pc_next  = seq_addr;
        if (branch) begin
            pc_next = align_down(branch_target);
        end
    end

endmodule : pc_next_sel

// File: rtl/program_counter.sv
// Instruction-fetch program counter: one PC register that either steps by one
// instruction word or loads an aligned branch target each clock.
module program_counter
    import program_counter_pkg::*;
#(
    parameter int                  PC_WIDTH     = DEFAULT_PC_WIDTH,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = PC_WIDTH'(DEFAULT_RESET_VECTOR),
    parameter int                  INSTR_BYTES  = DEFAULT_INSTR_BYTES
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                branch,
    input  logic [PC_WIDTH-1:0] branch_target,
    output logic [PC_WIDTH-1:0] pc_out
);

    localparam logic [PC_WIDTH-1:0] LOW_BITS = PC_WIDTH'(INSTR_BYTES) - PC_WIDTH'(1);

    if ((INSTR_BYTES < 1) || ((INSTR_BYTES & (INSTR_BYTES - 1)) != 0)) begin : g_bad_instr_bytes
        $error("program_counter: INSTR_BYTES must be a power of two");
    end
    if ((RESET_VECTOR & LOW_BITS) != '0) begin : g_bad_reset_vector
        $error("program_counter: RESET_VECTOR must be aligned to INSTR_BYTES");
    end

    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH-1:0] pc_next;

    pc_next_sel #(
        .PC_WIDTH    (PC_WIDTH),
        .INSTR_BYTES (INSTR_BYTES)
    ) u_next_sel (
        .branch        (branch),
        .branch_target (branch_target),
        .pc            (pc),
        .pc_next       (pc_next)
    );

    // Reset outranks branch, so it is applied here rather than in the selector.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc <= RESET_VECTOR;
        end else begin
            pc <= pc_next;
        end
    end

    assign pc_out = pc;

endmodule : program_counter

// File: tb/tb_program_counter.sv
// Directed bench for program_counter with default parameters (32-bit PC, 4-byte words).
module tb_program_counter;

    logic        clk = 1'b0;
    logic        reset;
    logic        branch;
    logic [31:0] branch_target;
    logic [31:0] pc_out;

    int tests_run = 0;
    int tests_failed = 0;

    program_counter dut (
        .clk           (clk),
        .reset         (reset),
        .branch        (branch),
        .branch_target (branch_target),
        .pc_out        (pc_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 32'h%08h, expected 32'h%08h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle away from it before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        branch = 1'b1;
        branch_target = 32'h100;

        // Reset overrides branch
        step(); check("reset_edge1", pc_out, 32'h0);
        step(); check("reset_edge2", pc_out, 32'h0);

        // Sequential run from reset vector
        reset = 1'b1;
        branch = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            step(); check($sformatf("seq_%0d", i), pc_out, 32'(i * 4));
        end

        // Back to PC = 8, then a one-edge branch to 0x40
        reset = 1'b0;
        step(); check("rerst", pc_out, 32'h0);
        reset = 1'b1;
        step(); check("rerst_seq4", pc_out, 32'h4);
        step(); check("rerst_seq8", pc_out, 32'h8);
        branch = 1'b1;
        branch_target = 32'h40;
        step(); check("branch_40", pc_out, 32'h40);
        branch = 1'b0;
        branch_target = 32'h999;
        step(); check("after_br_44", pc_out, 32'h44);
        step(); check("after_br_48", pc_out, 32'h48);

        // Mid-run reset with branch asserted in the same cycle
        reset = 1'b0;
        branch = 1'b1;
        branch_target = 32'h200;
        step(); check("midrun_reset", pc_out, 32'h0);
        reset = 1'b1;
        branch = 1'b0;
        step(); check("midrun_seq4", pc_out, 32'h4);
        step(); check("midrun_seq8", pc_out, 32'h8);

        // Misaligned target aligns down; level-held branch reloads each edge
        branch = 1'b1;
        branch_target = 32'h103;
        step(); check("align_hold1", pc_out, 32'h100);
        step(); check("align_hold2", pc_out, 32'h100);
        step(); check("align_hold3", pc_out, 32'h100);
        branch_target = 32'h7E;
        step(); check("align_7e", pc_out, 32'h7C);

        // Wrap-around at the top of the address space
        branch_target = 32'hFFFF_FFF8;
        step(); check("wrap_br", pc_out, 32'hFFFF_FFF8);
        branch = 1'b0;
        step(); check("wrap_fffc", pc_out, 32'hFFFF_FFFC);
        step(); check("wrap_0", pc_out, 32'h0000_0000);
        step(); check("wrap_4", pc_out, 32'h0000_0004);

        // Reset release edge taking a branch
        reset = 1'b0;
        step(); check("rel_rst", pc_out, 32'h0);
        reset = 1'b1;
        branch = 1'b1;
        branch_target = 32'h21;
        step(); check("rel_branch", pc_out, 32'h20);
        branch = 1'b0;
        step(); check("rel_seq", pc_out, 32'h24);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_program_counter

// File: doc/program_counter.md
# program_counter

Instruction-fetch program counter for the matmul core pipeline. Holds the address of the instruction currently being fetched. Each clock it either advances sequentially by one instruction word or loads a branch target. It sits at the head of the fetch stage, and `pc_out` drives the instruction-memory address.

## Interface
Parameters:
- `PC_WIDTH`, default 32: width of the address datapath.
- `RESET_VECTOR`, default 32'h0000_0000: value loaded while reset is asserted. Must be word-aligned.
- `INSTR_BYTES`, default 4: sequential increment in bytes. Must be a power of two.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: synchronous, active-low reset (0 = reset). Sampled only on the `clk` rising edge.
- `branch`, input, 1: when 1, the next PC is `branch_target` instead of the sequential address.
- `branch_target`, input, `PC_WIDTH`: redirect address. Valid whenever `branch` = 1.
- `pc_out`, output, `PC_WIDTH`: current PC. Registered output with no combinational path from the inputs.

## Operation
- The PC register is updated on every rising `clk` edge, using this priority:
  1. `reset` = 0: PC := `RESET_VECTOR`. Reset has the highest priority and overrides `branch`.
  2. `branch` = 1: PC := `branch_target` with its low log2(`INSTR_BYTES`) bits forced to 0. A misaligned target is silently aligned down.
  3. Otherwise: PC := PC + `INSTR_BYTES`, modulo 2^`PC_WIDTH`.
- Sequential increment wraps around. For example, 32'hFFFF_FFFC + 4 gives 32'h0000_0000, with no flag and no stall.
- There is no stall or enable input. The PC advances on every non-reset, non-branch cycle.
- `branch` is level-sensitive. If it is held high for N cycles, the PC reloads `branch_target` on each of those N edges.
- Inputs with X or Z values are not defined. The design is not required to sanitize them.

## Timing
- Reset value: `pc_out` = `RESET_VECTOR`, starting from the first rising edge with `reset` = 0. Before that first edge the value is undefined.
- Reset de-assertion: the first edge with `reset` = 1 produces `RESET_VECTOR` + `INSTR_BYTES`, or the aligned target if `branch` = 1 on that edge.
- Latency: `branch`/`branch_target` sampled at edge k appear on `pc_out` right after edge k. There are no delay slots inside this block.
- Reset asserted mid-run: `pc_out` returns to `RESET_VECTOR` on the next edge, even if `branch` is asserted in the same cycle.
- Changes to `branch_target` while `branch` = 0 have no effect.
- The block contains exactly one `PC_WIDTH`-bit register and no other state.

## Structure
- Shared core package holds:
  - `PC_WIDTH` and `INSTR_BYTES` defaults.
  - `RESET_VECTOR`.
  - An address typedef (`logic [PC_WIDTH-1:0]`), reused by fetch, branch unit and instruction memory.
- Next-PC selection logic is the natural sub-module, `pc_next_sel`. It is combinational: it computes the sequential address, aligns the target and selects by priority. The top level holds only the register.
- Elaboration-time checks:
  - `INSTR_BYTES` is a power of two.
  - `RESET_VECTOR` is aligned to `INSTR_BYTES`.

## Test plan
- Reset: hold `reset` = 0 for 2 edges with `branch` = 1 and `branch_target` = 32'h100 → `pc_out` = 0 after each edge. Reset overrides branch.
- Sequential run: release reset with `branch` = 0 and clock 6 edges → `pc_out` steps 4, 8, 12, 16, 20, 24.
- Branch: with PC = 8, pulse `branch` = 1 for one edge with target 32'h40 → `pc_out` = 32'h40, then 32'h44 and 32'h48 on the following edges.
- Alignment and hold:
  - Target 32'h103 with `branch` = 1 → `pc_out` = 32'h100.
  - Keep `branch` = 1 for 3 edges → `pc_out` stays 32'h100.
- Wrap-around: branch to 32'hFFFF_FFF8, then 2 sequential edges → 32'hFFFF_FFFC, then 32'h0000_0000.
- Mid-run reset: at PC = 32'h48 assert `reset` = 0 for one edge → `pc_out` = 0. Release → 4, 8.
